// File: rtl/mem_dump_reader.sv
// Streams a contiguous RAM range out over a valid/ready byte stream while the CPU is held off.
// Optional running checksum of streamed bytes: define MEM_DUMP_CHECKSUM_EN.
module mem_dump_reader #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [ADDR_W-1:0] end_addr_i,
   input  logic              abort_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_rd_en_o,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              out_last_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] checksum_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OCC_W = CNT_W + 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   remain_q, remain_d;   // reads still to issue after the current one
   logic                rd_en_q, rd_en_d;
   logic                rd_last_q, rd_last_d;
   logic                dv_q, dv_last_q;      // RAM data on the bus this cycle
   logic                busy_q, done_q;
   logic                flush;

   logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] last_q;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q;
   logic                push, pop;
   logic [OCC_W-1:0]    occ;

   assign push        = dv_q;
   assign out_valid_o = (count_q != '0);
   assign pop         = out_valid_o & out_ready_i;
   assign out_data_o  = out_valid_o ? fifo_q[rd_ptr_q] : '0;
   assign out_last_o  = out_valid_o & last_q[rd_ptr_q];
   assign mem_addr_o  = addr_q;
   assign mem_rd_en_o = rd_en_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

   // Slots committed after this edge: buffered + both pipeline stages, a same-cycle pop frees one
   assign occ = OCC_W'(count_q) + OCC_W'(rd_en_q) + OCC_W'(dv_q) - OCC_W'(pop);

   // Next-state and read issue
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      remain_d  = remain_q;
      rd_en_d   = 1'b0;
      rd_last_d = 1'b0;
      flush     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d   = READ;
               addr_d    = start_addr_i;
               remain_d  = ADDR_W'(end_addr_i - start_addr_i);
               rd_en_d   = 1'b1;
               rd_last_d = (end_addr_i == start_addr_i);
            end
         end
         READ: begin
            if (remain_q == '0) begin
               state_d = DRAIN;
            end else if (occ < OCC_W'(FIFO_DEPTH)) begin
               addr_d    = addr_q + ADDR_W'(1);
               remain_d  = remain_q - ADDR_W'(1);
               rd_en_d   = 1'b1;
               rd_last_d = (remain_q == ADDR_W'(1));
               if (remain_q == ADDR_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!rd_en_q && !dv_q && (count_q - CNT_W'(pop)) == '0) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort_i && (state_q == READ || state_q == DRAIN)) begin
         state_d   = IDLE;
         rd_en_d   = 1'b0;
         rd_last_d = 1'b0;
         flush     = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         remain_q  <= '0;
         rd_en_q   <= 1'b0;
         rd_last_q <= 1'b0;
         dv_q      <= 1'b0;
         dv_last_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         last_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         remain_q  <= remain_d;
         rd_en_q   <= rd_en_d;
         rd_last_q <= rd_last_d;
         dv_q      <= rd_en_q & ~flush;
         dv_last_q <= rd_last_q & ~flush;
         busy_q    <= (state_d != IDLE);
         done_q    <= (state_d == DONE);
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) begin
               fifo_q[wr_ptr_q] <= mem_data_i;
               last_q[wr_ptr_q] <= dv_last_q;
               wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

`ifdef MEM_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;
   logic              start_acc;

   assign start_acc  = (state_q == IDLE) & start_i;
   assign checksum_o = sum_q;

   // Modulo-2^DATA_W sum of handshaken bytes since the last accepted start
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                 sum_q <= '0;
      else if (start_acc || flush) sum_q <= '0;
      else if (pop)                sum_q <= sum_q + out_data_o;
   end
`else
   assign checksum_o = '0;
`endif

endmodule
